// File: rtl/ysyx_22040125_arb_pkg.sv
// Shared widths, defaults and state encoding for the IF/MEM bus arbiter.
package ysyx_22040125_arb_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned DATA_W         = 64;
  localparam int unsigned MASK_W         = 8;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 255;
  localparam int unsigned STARVE_W       = 8;
  localparam int unsigned TIMER_W        = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } arb_state_e;

  // Fetches always read the whole doubleword containing the instruction.
  function automatic logic [ADDR_W-1:0] dword_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/ysyx_22040125_arb_timer.sv
// Bus wait counter: counts enabled cycles and flags the one that reaches TIMEOUT.
module ysyx_22040125_arb_timer
  import ysyx_22040125_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of waiting cycles already elapsed before this one.
  assign expire = enable && !clear && (cnt_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_22040125_mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto one 64-bit memory bus with
// anti-starvation for fetch and a bus timeout that aborts with a sticky error.
module ysyx_22040125_mem_arbiter
  import ysyx_22040125_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [MASK_W-1:0] bus_wmask,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              pipe_stall,
  output logic              bus_err
);

  arb_state_e state_q, state_d;

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                if_hi_q;
  logic                if_ready_q, mem_ready_q;
  logic [WORD_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   mem_rdata_q;
  logic                bus_valid_q, bus_we_q, bus_err_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic [MASK_W-1:0]   bus_wmask_q;

  logic if_req_eff, mem_req_eff;
  logic grant_if, grant_mem, done, abort;
  logic timer_clear, timer_enable, timer_expire;
  logic [WORD_W-1:0] if_word;

  // A request seen alongside its own ready pulse is the one just served.
  assign if_req_eff  = if_req & ~if_ready_q;
  assign mem_req_eff = mem_req & ~mem_ready_q;

  assign timer_clear  = (state_q == IDLE);
  assign timer_enable = (state_q != IDLE) && !bus_ack;

  ysyx_22040125_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .enable(timer_enable),
    .expire(timer_expire)
  );

  always_comb begin
    state_d   = state_q;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req_eff && (!mem_req_eff || starve_q == STARVE_W'(STARVE_MAX))) begin
          state_d  = GNT_IF;
          grant_if = 1'b1;
        end else if (mem_req_eff) begin
          state_d   = GNT_MEM;
          grant_mem = 1'b1;
        end
      end
      GNT_IF, GNT_MEM: begin
        if (bus_ack) begin
          state_d = IDLE;
          done    = 1'b1;
        end else if (timer_expire) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_mem && if_req_eff && starve_q != STARVE_W'(STARVE_MAX)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  assign if_word = if_hi_q ? bus_rdata[DATA_W-1:WORD_W] : bus_rdata[WORD_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_hi_q     <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wmask_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if (grant_if) begin
        bus_valid_q <= 1'b1;
        bus_we_q    <= 1'b0;
        bus_wmask_q <= '0;
        bus_wdata_q <= '0;
        bus_addr_q  <= dword_align(if_addr);
        if_hi_q     <= if_addr[2];
      end
      if (grant_mem) begin
        bus_valid_q <= 1'b1;
        bus_we_q    <= mem_we;
        bus_wmask_q <= mem_wmask;
        bus_wdata_q <= mem_wdata;
        bus_addr_q  <= mem_addr;
      end
      if (done || abort) begin
        bus_valid_q <= 1'b0;
        if (state_q == GNT_IF) begin
          if_ready_q <= 1'b1;
          if_rdata_q <= abort ? '0 : if_word;
        end else begin
          mem_ready_q <= 1'b1;
          if (abort) begin
            mem_rdata_q <= '0;
          end else if (!bus_we_q) begin
            mem_rdata_q <= bus_rdata;
          end
        end
      end
      if (abort) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  assign if_ready   = if_ready_q;
  assign if_rdata   = if_rdata_q;
  assign mem_ready  = mem_ready_q;
  assign mem_rdata  = mem_rdata_q;
  assign bus_valid  = bus_valid_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_wmask  = bus_wmask_q;
  assign bus_err    = bus_err_q;
  assign pipe_stall = (if_req & ~if_ready_q) | (mem_req & ~mem_ready_q);

endmodule

// File: tb/tb_ysyx_22040125_mem_arbiter.sv
// Directed bench for the IF/MEM arbiter: table of single transactions plus
// hand-written sequences for priority, starvation, timeout and reset cases.
module tb_ysyx_22040125_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_ack;
  logic [63:0] bus_rdata;
  logic        pipe_stall;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22040125_mem_arbiter #(
    .STARVE_MAX(4),
    .TIMEOUT   (255)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wmask (bus_wmask),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .pipe_stall(pipe_stall),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          delay;
    logic [63:0] ack_rdata;
    logic [31:0] exp_addr;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input logic is_mem, input logic we, input logic [31:0] addr,
                              input logic [63:0] wdata, input logic [7:0] wmask,
                              input int delay, input logic [63:0] ack_rdata,
                              input logic [31:0] exp_addr, input logic [63:0] exp_rdata);
    vec_t v;
    v.is_mem = is_mem; v.we = we; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
    v.delay = delay; v.ack_rdata = ack_rdata; v.exp_addr = exp_addr; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
      mem_wmask = v.wmask;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1 check("pipe_stall_pending", 64'(pipe_stall), 64'(1));
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (bus_valid) break;
    end
    check("grant_seen", 64'(bus_valid), 64'(1));
    check("bus_addr", 64'(bus_addr), 64'(v.exp_addr));
    check("bus_we", 64'(bus_we), 64'(v.we));
    check("bus_wmask", 64'(bus_wmask), 64'(v.wmask));
    if (v.is_mem) check("bus_wdata", bus_wdata, v.wdata);
    repeat (v.delay) begin
      @(negedge clk);
      n++;
    end
    bus_ack = 1'b1;
    bus_rdata = v.ack_rdata;
    @(negedge clk);
    n++;
    bus_ack = 1'b0;
    check("latency", 64'(n), 64'(2 + v.delay));
    check("pipe_stall_at_ready", 64'(pipe_stall), 64'(0));
    if (v.is_mem) begin
      check("mem_ready", 64'(mem_ready), 64'(1));
      check("mem_rdata", mem_rdata, v.exp_rdata);
      mem_req = 1'b0;
    end else begin
      check("if_ready", 64'(if_ready), 64'(1));
      check("if_rdata", 64'(if_rdata), 64'(v.exp_rdata[31:0]));
      if_req = 1'b0;
    end
    @(negedge clk);
    check("ready_one_cycle", 64'(if_ready | mem_ready), 64'(0));
    check("bus_valid_dropped", 64'(bus_valid), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_valid;
    logic got_if [11];
    logic exp_if [11];
    int   ng;
    int   cnt;
    logic seen_ready;

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
    bus_ack = 1'b0; bus_rdata = '0;

    vecs[0] = mk(1'b0, 1'b0, 32'h8000_0004, 64'h0, 8'h00, 0, 64'h1111_2222_3333_4444,
                 32'h8000_0000, 64'h1111_2222);
    vecs[1] = mk(1'b0, 1'b0, 32'h8000_0010, 64'h0, 8'h00, 3, 64'hAAAA_BBBB_CCCC_DDDD,
                 32'h8000_0010, 64'hCCCC_DDDD);
    vecs[2] = mk(1'b1, 1'b0, 32'h8000_1000, 64'h0, 8'h00, 0, 64'h0123_4567_89AB_CDEF,
                 32'h8000_1000, 64'h0123_4567_89AB_CDEF);
    vecs[3] = mk(1'b1, 1'b1, 32'h8000_2008, 64'hDEAD_BEEF, 8'h0F, 1, 64'hFFFF_FFFF_FFFF_FFFF,
                 32'h8000_2008, 64'h0123_4567_89AB_CDEF);
    vecs[4] = mk(1'b1, 1'b0, 32'h8000_0007, 64'h0, 8'h00, 2, 64'h5555_6666_7777_8888,
                 32'h8000_0007, 64'h5555_6666_7777_8888);
    vecs[5] = mk(1'b0, 1'b0, 32'h8000_000F, 64'h0, 8'h00, 1, 64'h9999_AAAA_0000_1111,
                 32'h8000_0008, 64'h9999_AAAA);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_bus_valid", 64'(bus_valid), 64'(0));
    check("rst_bus_we", 64'(bus_we), 64'(0));
    check("rst_bus_wmask", 64'(bus_wmask), 64'(0));
    check("rst_bus_addr", 64'(bus_addr), 64'(0));
    check("rst_bus_wdata", bus_wdata, 64'(0));
    check("rst_ready", 64'({if_ready, mem_ready}), 64'(0));
    check("rst_if_rdata", 64'(if_rdata), 64'(0));
    check("rst_mem_rdata", mem_rdata, 64'(0));
    check("rst_bus_err", 64'(bus_err), 64'(0));
    check("rst_pipe_stall", 64'(pipe_stall), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Simultaneous requests: MEM first, IF granted in the mem_ready cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8000_0008;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_1000;
    @(negedge clk);
    check("both_first_valid", 64'(bus_valid), 64'(1));
    check("both_first_is_mem", 64'(bus_addr), 64'(32'h8000_1000));
    bus_ack = 1'b1; bus_rdata = 64'h0;
    @(negedge clk);
    bus_ack = 1'b0;
    check("both_mem_ready", 64'(mem_ready), 64'(1));
    mem_req = 1'b0;
    @(negedge clk);
    check("both_if_valid", 64'(bus_valid), 64'(1));
    check("both_if_addr", 64'(bus_addr), 64'(32'h8000_0008));
    bus_ack = 1'b1; bus_rdata = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    bus_ack = 1'b0;
    check("both_if_ready", 64'(if_ready), 64'(1));
    check("both_if_rdata", 64'(if_rdata), 64'(32'h1234_5678));
    if_req = 1'b0;
    @(negedge clk);

    // Starvation: with MEM always requesting, IF wins after 4 MEM grants made
    // while it waits. IF drops its request during ready cycles so the 4 grants
    // are all taken with IF waiting; the first MEM grant after IF is served
    // happens in if_ready's cycle and does not count.
    exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_3000;
    if_req = 1'b1; if_addr = 32'h8000_5000;
    prev_valid = 1'b0;
    ng = 0;
    for (int c = 0; c < 300 && ng < 11; c++) begin
      @(negedge clk);
      if (bus_valid && !prev_valid) begin
        got_if[ng] = (bus_addr == 32'h8000_5000);
        ng++;
      end
      prev_valid = bus_valid;
      bus_ack = bus_valid;
      bus_rdata = 64'h0;
      if_req = !mem_ready && !if_ready;
    end
    check("starve_grant_count", 64'(ng), 64'(11));
    for (int g = 0; g < 11; g++) check($sformatf("starve_grant_%0d_is_if", g),
                                       64'(got_if[g]), 64'(exp_if[g]));
    mem_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    bus_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Ack arriving in the very cycle the timer would expire wins
    do_reset();
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_4000;
    @(negedge clk);
    cnt = bus_valid ? 1 : 0;
    for (int k = 2; k <= 255; k++) begin
      @(negedge clk);
      if (bus_valid) cnt++;
    end
    check("ack_edge_valid_cycles", 64'(cnt), 64'(255));
    bus_ack = 1'b1; bus_rdata = 64'h77;
    @(negedge clk);
    bus_ack = 1'b0;
    check("ack_edge_mem_ready", 64'(mem_ready), 64'(1));
    check("ack_edge_mem_rdata", mem_rdata, 64'h77);
    check("ack_edge_bus_err", 64'(bus_err), 64'(0));
    mem_req = 1'b0;
    @(negedge clk);

    // No ack: abort after 255 waiting cycles with zero data and sticky error
    mem_req = 1'b1; mem_addr = 32'h8000_4008;
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      if (!bus_valid) break;
      cnt++;
      @(negedge clk);
    end
    check("timeout_valid_cycles", 64'(cnt), 64'(255));
    check("timeout_mem_ready", 64'(mem_ready), 64'(1));
    check("timeout_mem_rdata", mem_rdata, 64'h0);
    check("timeout_bus_err", 64'(bus_err), 64'(1));
    mem_req = 1'b0;

    // Ack while idle is ignored
    bus_ack = 1'b1;
    seen_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (if_ready || mem_ready || bus_valid) seen_ready = 1'b1;
    end
    bus_ack = 1'b0;
    check("idle_ack_ignored", 64'(seen_ready), 64'(0));
    check("bus_err_sticky_idle", 64'(bus_err), 64'(1));
    run_vec(vecs[0]);
    check("bus_err_sticky_after_ok", 64'(bus_err), 64'(1));

    // Reset during an IF grant aborts silently
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8000_6004;
    @(negedge clk);
    check("rst_mid_granted", 64'(bus_valid), 64'(1));
    #2 rst = 1'b1;
    #1 check("rst_mid_valid_low", 64'(bus_valid), 64'(0));
    check("rst_mid_bus_err_clear", 64'(bus_err), 64'(0));
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus_ack = 1'b1; bus_rdata = 64'hFFFF_0000_FFFF_0000;
    seen_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (if_ready || bus_valid) seen_ready = 1'b1;
    end
    bus_ack = 1'b0;
    check("rst_mid_no_if_ready", 64'(seen_ready), 64'(0));
    check("rst_mid_if_rdata", 64'(if_rdata), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
